// File: rtl/pet_status_fsm.sv
// Virtual-pet status engine: ages four need levels, applies button actions,
// and decides intro/awake/asleep/dead for the LCD figure controller.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low; clears everything
//   btn_feed       one-cycle pulse: alimentacion +2
//   btn_play       one-cycle pulse: diversion +2, energia -1
//   btn_heal       one-cycle pulse: salud +2
//   btn_sleep      one-cycle pulse: toggles sleep
//   select_figures registered {mood[1:0], stat[1:0]}
//   sleep          registered 00 awake, 01 asleep, 11 dead
//   levels         {salud, energia, diversion, alimentacion}, 3 bits each

module pet_status_fsm #(
    parameter int TICK_CYCLES  = 50_000_000,
    parameter int DECAY_TICKS  = 10,
    parameter int ROTATE_TICKS = 3,
    parameter int LEVEL_MAX    = 5,
    parameter int HAPPY_MIN    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_feed,
    input  logic        btn_play,
    input  logic        btn_heal,
    input  logic        btn_sleep,
    output logic [3:0]  select_figures,
    output logic [1:0]  sleep,
    output logic [11:0] levels
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int RW = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_TICKS - 1);
    localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_TICKS - 1);

    localparam logic [2:0] LVL   = 3'(LEVEL_MAX);
    localparam logic [2:0] HAPPY = 3'(HAPPY_MIN);

    localparam logic [1:0] ST_SALUD = 2'b00;
    localparam logic [1:0] ST_ENER  = 2'b01;
    localparam logic [1:0] ST_DIV   = 2'b11;
    localparam logic [1:0] ST_ALIM  = 2'b10;

    localparam logic [1:0] MOOD_SAD     = 2'b00;
    localparam logic [1:0] MOOD_HAPPY   = 2'b01;
    localparam logic [1:0] MOOD_NEUTRAL = 2'b10;

    localparam logic [1:0] SL_AWAKE  = 2'b00;
    localparam logic [1:0] SL_ASLEEP = 2'b01;
    localparam logic [1:0] SL_DEAD   = 2'b11;

    typedef enum logic [1:0] {
        INTRO,
        AWAKE,
        ASLEEP,
        DEAD
    } state_t;

    state_t        state;
    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] decay_cnt;
    logic [RW-1:0] rot_cnt;
    logic [1:0]    stat_q;

    logic [2:0] salud;
    logic [2:0] energia;
    logic [2:0] diversion;
    logic [2:0] alimentacion;

    logic tick;
    logic decay_fire;
    logic any_zero;

    logic take_sleep;
    logic take_heal;
    logic take_feed;
    logic take_play;
    logic any_btn;

    logic       pick_valid;
    logic [1:0] pick_stat;

    logic [2:0] d_salud;
    logic [2:0] d_energia;
    logic [2:0] d_diversion;
    logic [2:0] d_alimentacion;

    logic [2:0] n_salud;
    logic [2:0] n_energia;
    logic [2:0] n_diversion;
    logic [2:0] n_alimentacion;

    logic       all_happy;
    logic [1:0] mood_now;
    logic [1:0] stat_now;
    logic [1:0] sleep_now;

    function automatic logic [2:0] sat_add(input logic [2:0] a,
                                           input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, LVL}) ? LVL : s[2:0];
    endfunction

    function automatic logic [2:0] sat_sub(input logic [2:0] a,
                                           input logic [2:0] b);
        return (a < b) ? 3'd0 : (a - b);
    endfunction

    function automatic logic [1:0] next_stat(input logic [1:0] s);
        logic [1:0] r;
        r = ST_SALUD;
        unique case (s)
            ST_SALUD: r = ST_ENER;
            ST_ENER:  r = ST_DIV;
            ST_DIV:   r = ST_ALIM;
            ST_ALIM:  r = ST_SALUD;
        endcase
        return r;
    endfunction

    assign levels = {salud, energia, diversion, alimentacion};

    assign tick       = (pre_cnt == PRE_LAST);
    assign decay_fire = (state == AWAKE) && tick && (decay_cnt == DEC_LAST);

    // Salud only suffers when another need is already exhausted,
    // judged on the values before this decay.
    assign any_zero = (energia == 3'd0) || (diversion == 3'd0) ||
                      (alimentacion == 3'd0);

    // One button per cycle: sleep > heal > feed > play.
    assign take_sleep = btn_sleep;
    assign take_heal  = btn_heal & ~btn_sleep;
    assign take_feed  = btn_feed & ~btn_heal & ~btn_sleep;
    assign take_play  = btn_play & ~btn_feed & ~btn_heal & ~btn_sleep;
    assign any_btn    = take_sleep | take_heal | take_feed | take_play;

    always_comb begin
        pick_valid = 1'b1;
        pick_stat  = ST_SALUD;
        unique case (1'b1)
            take_heal: pick_stat = ST_SALUD;
            take_feed: pick_stat = ST_ALIM;
            take_play: pick_stat = ST_DIV;
            default:   pick_valid = 1'b0;
        endcase
    end

    // Decay is applied first, then the button on top of it.
    always_comb begin
        d_salud        = salud;
        d_energia      = energia;
        d_diversion    = diversion;
        d_alimentacion = alimentacion;
        if (decay_fire) begin
            d_energia      = sat_sub(energia, 3'd1);
            d_diversion    = sat_sub(diversion, 3'd1);
            d_alimentacion = sat_sub(alimentacion, 3'd1);
            if (any_zero) begin
                d_salud = sat_sub(salud, 3'd1);
            end
        end
    end

    always_comb begin
        n_salud        = d_salud;
        n_energia      = d_energia;
        n_diversion    = d_diversion;
        n_alimentacion = d_alimentacion;
        if (take_heal) begin
            n_salud = sat_add(d_salud, 3'd2);
        end
        if (take_feed) begin
            n_alimentacion = sat_add(d_alimentacion, 3'd2);
        end
        if (take_play) begin
            n_diversion = sat_add(d_diversion, 3'd2);
            n_energia   = sat_sub(d_energia, 3'd1);
        end
    end

    assign all_happy = (salud >= HAPPY) && (energia >= HAPPY) &&
                       (diversion >= HAPPY) && (alimentacion >= HAPPY);

    always_comb begin
        mood_now  = all_happy ? MOOD_HAPPY : MOOD_SAD;
        stat_now  = stat_q;
        sleep_now = SL_AWAKE;
        unique case (state)
            INTRO: begin
                mood_now = MOOD_NEUTRAL;
                stat_now = ST_SALUD;
            end
            AWAKE: begin
                stat_now = stat_q;
            end
            ASLEEP: begin
                stat_now  = ST_ENER;
                sleep_now = SL_ASLEEP;
            end
            DEAD: begin
                stat_now  = ST_SALUD;
                sleep_now = SL_DEAD;
            end
        endcase
    end

    // Outputs are sampled from the current state/levels, so they trail
    // any level or state change by exactly one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= INTRO;
            pre_cnt        <= '0;
            decay_cnt      <= '0;
            rot_cnt        <= '0;
            stat_q         <= ST_SALUD;
            salud          <= LVL;
            energia        <= LVL;
            diversion      <= LVL;
            alimentacion   <= LVL;
            select_figures <= {MOOD_NEUTRAL, ST_SALUD};
            sleep          <= SL_AWAKE;
        end else begin
            pre_cnt        <= tick ? '0 : pre_cnt + 1'b1;
            select_figures <= {mood_now, stat_now};
            sleep          <= sleep_now;

            unique case (state)
                INTRO: begin
                    if (any_btn) begin
                        salud        <= n_salud;
                        energia      <= n_energia;
                        diversion    <= n_diversion;
                        alimentacion <= n_alimentacion;
                        state        <= take_sleep ? ASLEEP : AWAKE;
                        if (pick_valid) begin
                            stat_q  <= pick_stat;
                            rot_cnt <= '0;
                        end
                    end
                end

                AWAKE: begin
                    if (salud == 3'd0) begin
                        state <= DEAD;
                    end else begin
                        salud        <= n_salud;
                        energia      <= n_energia;
                        diversion    <= n_diversion;
                        alimentacion <= n_alimentacion;

                        if (tick) begin
                            decay_cnt <= decay_fire ? '0 : decay_cnt + 1'b1;
                        end

                        // A care action pins its stat and restarts the
                        // rotation, overriding a same-cycle rotate step.
                        if (pick_valid) begin
                            stat_q  <= pick_stat;
                            rot_cnt <= '0;
                        end else if (tick) begin
                            if (rot_cnt == ROT_LAST) begin
                                rot_cnt <= '0;
                                stat_q  <= next_stat(stat_q);
                            end else begin
                                rot_cnt <= rot_cnt + 1'b1;
                            end
                        end

                        if (take_sleep) begin
                            state <= ASLEEP;
                        end
                    end
                end

                ASLEEP: begin
                    if (tick) begin
                        energia <= sat_add(energia, 3'd1);
                    end
                    if (btn_sleep || (energia == LVL)) begin
                        state <= AWAKE;
                    end
                end

                DEAD: begin
                    state <= DEAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pet_status_fsm.sv
// Directed bench for pet_status_fsm: table of {buttons, cycles, expected
// outputs} rows plus a hand sequence for asynchronous reset while asleep.

module tb_pet_status_fsm;

    logic        clk;
    logic        reset;
    logic        feed;
    logic        play;
    logic        heal;
    logic        slp_btn;
    logic [3:0]  sf;
    logic [1:0]  slp;
    logic [11:0] lv;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rst;
        logic [3:0]  btn;
        int          cycles;
        logic [3:0]  sf;
        logic [1:0]  slp;
        logic [11:0] lv;
        string       name;
    } vec_t;

    vec_t vecs[$];

    pet_status_fsm #(
        .TICK_CYCLES  (4),
        .DECAY_TICKS  (2),
        .ROTATE_TICKS (3),
        .LEVEL_MAX    (5),
        .HAPPY_MIN    (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_feed       (feed),
        .btn_play       (play),
        .btn_heal       (heal),
        .btn_sleep      (slp_btn),
        .select_figures (sf),
        .sleep          (slp),
        .levels         (lv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // btn = {feed, play, heal, sleep}
    task automatic add(input logic r, input logic [3:0] b, input int c,
                       input logic [3:0] s, input logic [1:0] sl,
                       input logic [11:0] l, input string nm);
        vec_t v;
        v.rst    = r;
        v.btn    = b;
        v.cycles = c;
        v.sf     = s;
        v.slp    = sl;
        v.lv     = l;
        v.name   = nm;
        vecs.push_back(v);
    endtask

    task automatic run_row(input vec_t v);
        if (v.rst) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end
        {feed, play, heal, slp_btn} = v.btn;
        @(posedge clk);
        @(negedge clk);
        {feed, play, heal, slp_btn} = 4'b0000;
        repeat (v.cycles - 1) @(negedge clk);
        chk({v.name, ".sf"}, {8'h00, sf}, {8'h00, v.sf});
        chk({v.name, ".sleep"}, {10'h000, slp}, {10'h000, v.slp});
        chk({v.name, ".levels"}, lv, v.lv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        feed    = 1'b0;
        play    = 1'b0;
        heal    = 1'b0;
        slp_btn = 1'b0;

        // Scenario A: intro, decay to death, dead ignores inputs.
        add(1, 4'b0000, 10, 4'b1000, 2'b00, 12'hB6D, "intro10");
        add(0, 4'b0000, 10, 4'b1000, 2'b00, 12'hB6D, "intro20");
        add(0, 4'b1000,  2, 4'b0110, 2'b00, 12'hB6D, "feed_intro");
        add(0, 4'b0000, 24, 4'b0001, 2'b00, 12'hA92, "decay3");
        add(0, 4'b0000, 47, 4'b0001, 2'b00, 12'h200, "salud1");
        add(0, 4'b0000,  8, 4'b0001, 2'b00, 12'h000, "salud0");
        add(0, 4'b0000,  1, 4'b0000, 2'b11, 12'h000, "dead");
        add(0, 4'b1111,  2, 4'b0000, 2'b11, 12'h000, "dead_all");
        add(0, 4'b1000,  1, 4'b0000, 2'b11, 12'h000, "dead_feed");
        add(0, 4'b0100,  1, 4'b0000, 2'b11, 12'h000, "dead_play");
        add(0, 4'b0010,  1, 4'b0000, 2'b11, 12'h000, "dead_heal");
        add(0, 4'b0001,  1, 4'b0000, 2'b11, 12'h000, "dead_sleep");
        add(0, 4'b0000,  8, 4'b0000, 2'b11, 12'h000, "dead_hold");

        // Scenario B: play down energia, sleep, wake, priority, decay+play.
        add(1, 4'b0100,  1, 4'b1000, 2'b00, 12'hB2D, "play1");
        add(0, 4'b0100,  1, 4'b0111, 2'b00, 12'hAED, "play2");
        add(0, 4'b0100,  1, 4'b0111, 2'b00, 12'hAAD, "play3");
        add(0, 4'b0000,  1, 4'b0011, 2'b00, 12'hAAD, "sad_e2");
        add(0, 4'b0001,  2, 4'b0001, 2'b01, 12'hAAD, "go_sleep");
        add(0, 4'b0000,  3, 4'b0101, 2'b01, 12'hAED, "sleep_e3");
        add(0, 4'b0000,  8, 4'b0101, 2'b01, 12'hB6D, "sleep_e5");
        add(0, 4'b0000,  1, 4'b0111, 2'b00, 12'hB6D, "woke");
        add(0, 4'b0000,  3, 4'b0111, 2'b00, 12'hB24, "decay_resume");
        add(0, 4'b1001,  1, 4'b0111, 2'b00, 12'hB24, "sleep_feed");
        add(0, 4'b0000,  1, 4'b0101, 2'b01, 12'hB24, "sleep_won");
        add(0, 4'b0000,  3, 4'b0111, 2'b00, 12'hB64, "woke2");
        add(0, 4'b0000,  5, 4'b0110, 2'b00, 12'hB64, "rotate");
        add(0, 4'b0100,  1, 4'b0110, 2'b00, 12'hAEB, "decay_play");
        add(0, 4'b0000,  1, 4'b0111, 2'b00, 12'hAEB, "play_stat");

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i]);
        end

        // Asynchronous reset while asleep, between clock edges.
        slp_btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        slp_btn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("asleep.sleep", {10'h000, slp}, 12'h001);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async.sf", {8'h00, sf}, 12'h008);
        chk("async.sleep", {10'h000, slp}, 12'h000);
        chk("async.levels", lv, 12'hB6D);
        @(posedge clk);
        #1;
        chk("held.sf", {8'h00, sf}, 12'h008);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post.sf", {8'h00, sf}, 12'h008);
        chk("post.sleep", {10'h000, slp}, 12'h000);
        chk("post.levels", lv, 12'hB6D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
